// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register plus EX operand network: forwarding, operand muxes, load-use detect.
// Optional macro XGRISCV_FWD_EN enables forwarding, capture/stall bypass and lu_stall.
module ex_operand_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [1:0]      id_alusrca,
  input  logic            id_alusrcb,
  input  logic [3:0]      id_aluctrl,
  input  logic            id_regwrite,
  input  logic            id_memwrite,
  input  logic            id_memtoreg,
  input  logic            exmem_regwrite,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_aluout,
  input  logic            memwb_regwrite,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_wdata,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [4:0]      ex_shamt,
  output logic [3:0]      ex_aluctrl,
  output logic [XLEN-1:0] ex_wdata,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memwrite,
  output logic            ex_memtoreg,
  output logic            lu_stall
);

  localparam int unsigned RW = 5;

  logic [XLEN-1:0] rd1_q, rd2_q;
  logic [RW-1:0]   rs1_q, rs2_q;
  logic [1:0]      alusrca_q;
  logic            alusrcb_q;

  logic [XLEN-1:0] load_rd1, load_rd2, hold_rd1, hold_rd2;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

`ifdef XGRISCV_FWD_EN
  // MEM/WB bypass into the captured/held register-file data (no write-through in the RF)
  always_comb begin
    load_rd1 = id_rd1;
    load_rd2 = id_rd2;
    hold_rd1 = rd1_q;
    hold_rd2 = rd2_q;
    if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == id_rs1)) load_rd1 = memwb_wdata;
    if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == id_rs2)) load_rd2 = memwb_wdata;
    if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs1_q))  hold_rd1 = memwb_wdata;
    if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs2_q))  hold_rd2 = memwb_wdata;
  end

  // EX/MEM beats MEM/WB; x0 never forwards
  always_comb begin
    fwd_rs1 = rd1_q;
    fwd_rs2 = rd2_q;
    if (rs1_q != '0) begin
      if (exmem_regwrite && (exmem_rd == rs1_q))      fwd_rs1 = exmem_aluout;
      else if (memwb_regwrite && (memwb_rd == rs1_q)) fwd_rs1 = memwb_wdata;
    end
    if (rs2_q != '0) begin
      if (exmem_regwrite && (exmem_rd == rs2_q))      fwd_rs2 = exmem_aluout;
      else if (memwb_regwrite && (memwb_rd == rs2_q)) fwd_rs2 = memwb_wdata;
    end
  end

  assign lu_stall = ex_valid & ex_memtoreg & (ex_rd != '0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));
`else
  assign load_rd1 = id_rd1;
  assign load_rd2 = id_rd2;
  assign hold_rd1 = rd1_q;
  assign hold_rd2 = rd2_q;
  assign fwd_rs1  = rd1_q;
  assign fwd_rs2  = rd2_q;
  assign lu_stall = 1'b0;

  logic unused_fwd;
  assign unused_fwd = ^{exmem_regwrite, exmem_rd, exmem_aluout,
                        memwb_regwrite, memwb_rd, memwb_wdata, rs1_q, rs2_q};
`endif

  // ID/EX register: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_imm      <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      ex_rd       <= '0;
      alusrca_q   <= '0;
      alusrcb_q   <= 1'b0;
      ex_aluctrl  <= '0;
      ex_regwrite <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
    end else if (stall) begin
      rd1_q <= hold_rd1;
      rd2_q <= hold_rd2;
    end else begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_imm      <= id_imm;
      rd1_q       <= load_rd1;
      rd2_q       <= load_rd2;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      ex_rd       <= id_rd;
      alusrca_q   <= id_alusrca;
      alusrcb_q   <= id_alusrcb;
      ex_aluctrl  <= id_aluctrl;
      ex_regwrite <= id_regwrite;
      ex_memwrite <= id_memwrite;
      ex_memtoreg <= id_memtoreg;
    end
  end

  // Operand select
  always_comb begin
    case (alusrca_q)
      2'b00:   ex_a = fwd_rs1;
      2'b01:   ex_a = ex_pc;
      default: ex_a = '0;
    endcase
  end

  assign ex_b     = alusrcb_q ? ex_imm : fwd_rs2;
  assign ex_wdata = fwd_rs2;
  assign ex_shamt = ex_imm[RW-1:0];

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage; expectations follow XGRISCV_FWD_EN when defined.
module tb_ex_operand_stage;

  localparam int unsigned XLEN = 32;

`ifdef XGRISCV_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn, stall, flush, id_valid;
  logic [XLEN-1:0] id_pc, id_imm, id_rd1, id_rd2;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [1:0]      id_alusrca;
  logic            id_alusrcb;
  logic [3:0]      id_aluctrl;
  logic            id_regwrite, id_memwrite, id_memtoreg;
  logic            exmem_regwrite, memwb_regwrite;
  logic [4:0]      exmem_rd, memwb_rd;
  logic [XLEN-1:0] exmem_aluout, memwb_wdata;
  logic            ex_valid, ex_regwrite, ex_memwrite, ex_memtoreg, lu_stall;
  logic [XLEN-1:0] ex_a, ex_b, ex_wdata, ex_pc, ex_imm;
  logic [4:0]      ex_shamt, ex_rd;
  logic [3:0]      ex_aluctrl;

  int n_cmp = 0;
  int n_bad = 0;

  ex_operand_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alusrca(id_alusrca), .id_alusrcb(id_alusrcb), .id_aluctrl(id_aluctrl),
    .id_regwrite(id_regwrite), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_aluout(exmem_aluout),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_shamt(ex_shamt),
    .ex_aluctrl(ex_aluctrl), .ex_wdata(ex_wdata), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .lu_stall(lu_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One active edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_bubble();
    id_valid = 0; id_pc = '0; id_imm = '0; id_rd1 = '0; id_rd2 = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alusrca = '0; id_alusrcb = 0;
    id_aluctrl = '0; id_regwrite = 0; id_memwrite = 0; id_memtoreg = 0;
  endtask

  initial begin
    // Reset held for 2 edges with random inputs
    rstn = 0; stall = 0; flush = 0;
    id_valid = 1; id_pc = $urandom; id_imm = $urandom; id_rd1 = $urandom; id_rd2 = $urandom;
    id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom);
    id_alusrca = 2'($urandom); id_alusrcb = 1'($urandom); id_aluctrl = 4'($urandom);
    id_regwrite = 1; id_memwrite = 1; id_memtoreg = 1;
    exmem_regwrite = 1; exmem_rd = 5'($urandom); exmem_aluout = $urandom;
    memwb_regwrite = 1; memwb_rd = 5'($urandom); memwb_wdata = $urandom;
    step(); step();
    check("rst_valid", 32'(ex_valid), 0);
    check("rst_a", ex_a, 0);
    check("rst_b", ex_b, 0);
    check("rst_wdata", ex_wdata, 0);
    check("rst_pc", ex_pc, 0);
    check("rst_imm", ex_imm, 0);
    check("rst_shamt", 32'(ex_shamt), 0);
    check("rst_aluctrl", 32'(ex_aluctrl), 0);
    check("rst_rd", 32'(ex_rd), 0);
    check("rst_ctrl", 32'({ex_regwrite, ex_memwrite, ex_memtoreg}), 0);
    check("rst_lu", 32'(lu_stall), 0);

    // Plain ALU op, then forwarding priority purely combinational
    rstn = 1; exmem_regwrite = 0; memwb_regwrite = 0;
    id_bubble();
    id_valid = 1; id_rs1 = 5; id_rs2 = 6; id_rd1 = 32'h11; id_rd2 = 32'h66; id_rd = 3;
    id_aluctrl = 4'h3; id_regwrite = 1; id_imm = 32'h0000_0ABC; id_pc = 32'h40;
    step();
    check("alu_valid", 32'(ex_valid), 1);
    check("alu_a", ex_a, 32'h11);
    check("alu_b", ex_b, 32'h66);
    check("alu_shamt", 32'(ex_shamt), 32'h1C);
    check("alu_aluctrl", 32'(ex_aluctrl), 3);
    check("alu_pc", ex_pc, 32'h40);
    check("alu_rd", 32'(ex_rd), 3);
    exmem_regwrite = 1; exmem_rd = 5; exmem_aluout = 32'h22;
    memwb_regwrite = 1; memwb_rd = 5; memwb_wdata = 32'h33;
    #1;
    check("fwd_exmem_pri", ex_a, FWD ? 32'h22 : 32'h11);
    exmem_regwrite = 0;
    #1;
    check("fwd_memwb", ex_a, FWD ? 32'h33 : 32'h11);
    check("fwd_b_nomatch", ex_b, 32'h66);
    memwb_regwrite = 0;
    #1;
    check("fwd_none", ex_a, 32'h11);

    // x0 never forwards, neither at capture nor combinationally
    id_bubble();
    id_valid = 1;
    exmem_regwrite = 1; exmem_rd = 0; exmem_aluout = 32'hDEAD;
    memwb_regwrite = 1; memwb_rd = 0; memwb_wdata = 32'hBEEF;
    step();
    check("x0_b", ex_b, 0);
    check("x0_a", ex_a, 0);
    check("x0_wdata", ex_wdata, 0);
    exmem_regwrite = 0; memwb_regwrite = 0;

    // LUI / AUIPC / alusrca=11
    id_bubble();
    id_valid = 1; id_alusrca = 2'b10; id_alusrcb = 1; id_imm = 32'h1234_5000;
    id_pc = 32'h200; id_rs1 = 9; id_rd1 = 32'h99;
    step();
    check("lui_a", ex_a, 0);
    check("lui_b", ex_b, 32'h1234_5000);
    id_alusrca = 2'b01; id_pc = 32'h100;
    step();
    check("auipc_a", ex_a, 32'h100);
    id_alusrca = 2'b11;
    step();
    check("srca11_a", ex_a, 0);

    // Capture bypass: MEM/WB retires rs1 in the same cycle ID reads it
    id_bubble();
    id_valid = 1; id_rs1 = 4; id_rd1 = 32'h44;
    memwb_regwrite = 1; memwb_rd = 4; memwb_wdata = 32'h4A4A;
    step();
    memwb_regwrite = 0;
    #1;
    check("cap_bypass_a", ex_a, FWD ? 32'h4A4A : 32'h44);

    // Load-use: load rd=7 in EX, ID reads rs2=7
    id_bubble();
    id_valid = 1; id_rs1 = 1; id_rd1 = 32'h1000; id_alusrcb = 1; id_imm = 4;
    id_rd = 7; id_regwrite = 1; id_memtoreg = 1;
    step();
    id_bubble();
    id_valid = 1; id_rs1 = 8; id_rd1 = 32'h8; id_rs2 = 7; id_rd2 = 32'hAA;
    id_alusrcb = 1; id_memwrite = 1; id_pc = 32'h300;
    #1;
    check("lu_hit", 32'(lu_stall), FWD ? 1 : 0);
    id_rs2 = 9;
    #1;
    check("lu_miss", 32'(lu_stall), 0);
    id_rs2 = 7;
    step();
    check("st_wdata_stale", ex_wdata, 32'hAA);
    check("lu_after_store", 32'(lu_stall), 0);
    // Stall one cycle while MEM/WB retires x7
    stall = 1; memwb_regwrite = 1; memwb_rd = 7; memwb_wdata = 32'h55;
    id_pc = 32'hFFF; id_rd = 12;
    step();
    memwb_regwrite = 0;
    #1;
    check("stall_reload", ex_wdata, FWD ? 32'h55 : 32'hAA);
    check("stall_pc_hold", ex_pc, 32'h300);
    check("stall_rd_hold", 32'(ex_rd), 0);
    check("stall_memwrite", 32'(ex_memwrite), 1);

    // Flush wins over stall
    flush = 1;
    step();
    check("flush_valid", 32'(ex_valid), 0);
    check("flush_ctrl", 32'({ex_regwrite, ex_memwrite, ex_memtoreg}), 0);
    check("flush_pc", ex_pc, 0);
    flush = 0; stall = 0;

    // Reset mid-instruction gives a bubble
    id_bubble();
    id_valid = 1; id_pc = 32'h500; id_rd = 2; id_regwrite = 1;
    step();
    check("pre_rst_valid", 32'(ex_valid), 1);
    rstn = 0;
    step();
    check("mid_rst_valid", 32'(ex_valid), 0);
    check("mid_rst_pc", ex_pc, 0);
    check("mid_rst_rd", 32'(ex_rd), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
